shoot_pulse_ctrl: RTL and testbench
===================================

SHOOT_PULSE_CTRL -- requirements
Module: shoot_pulse_ctrl

Interface
REQ-001 SHALL take parameter PRESCALE, default 50, clk cycles per timing tick (1 us at 50 MHz); legal range 2..65535.
REQ-002 SHALL take parameter COOLDOWN_TICKS, default 20000, ticks of lockout after each pulse; legal range 1..2^20-1.
REQ-003 SHALL take parameter MAX_WIDTH, default 8000, ticks; a larger requested width is clamped to this value.
REQ-004 Port: clk  in  1  system clock; all logic on its rising edge.
REQ-005 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-006 Port: kick_req  in  1  single-cycle strobe requesting one shot.
REQ-007 Port: kick_width  in  16  pulse width in ticks, sampled only on an accepted kick_req.
REQ-008 Port: chip_sel  in  1  sampled with kick_req; 1 selects the chip solenoid, 0 selects the flat kick solenoid.
REQ-009 Port: ball_det  in  1  asynchronous infrared ball-present input, high when the ball is present.
REQ-010 Port: kick_out  out  1  flat solenoid drive, registered.
REQ-011 Port: chip_out  out  1  chip solenoid drive, registered.
REQ-012 Port: shoot_off  out  1  registered status, 1 when the shooter cannot accept a request; feeds the 1-bit PIO in_port.

Function
REQ-013 A free-running prescaler SHALL count 0..PRESCALE-1 and assert a one-cycle tick when it reaches PRESCALE-1; reset returns the count to 0.
REQ-014 The FSM SHALL have three states: IDLE, FIRE and COOLDOWN.
REQ-015 IDLE->FIRE SHALL occur on a kick_req with clamped width>0 (and the ball gate met when enabled); the width, chip_sel and prescaler are latched and cleared in the same edge.
REQ-016 A kick_req with width 0 SHALL be ignored; the FSM stays in IDLE and no output changes.
REQ-017 In FIRE, exactly one of kick_out or chip_out SHALL be high, from the cycle after acceptance for exactly W*PRESCALE clk cycles, where W = min(kick_width, MAX_WIDTH).
REQ-018 FIRE->COOLDOWN SHALL occur on the tick that brings the width counter to 0; both drives go low on that same edge.
REQ-019 COOLDOWN->IDLE SHALL occur after COOLDOWN_TICKS ticks.
REQ-020 kick_req in FIRE or COOLDOWN SHALL be dropped; there is no queuing and no extension of the current pulse.
REQ-021 shoot_off SHALL be 1 in FIRE and COOLDOWN and 0 in IDLE; it is registered, so it rises in the same cycle as the drive.
REQ-022 kick_out and chip_out SHALL never be high together in any cycle.
REQ-023 ball_det SHALL pass through a 2-flop synchronizer before any use.
REQ-024 Widths SHALL be compared and counted unsigned; the counters SHALL NOT wrap.

Reset
REQ-025 reset_n low SHALL force IDLE, kick_out=0, chip_out=0, shoot_off=0 and clear all counters and synchronizer flops, taking effect immediately without waiting for clk.
REQ-026 Reset asserted mid-FIRE SHALL drop the drives at once; the first accepted request after release starts a full-width pulse.

Configuration
REQ-027 With SHOOT_BALL_GATE_EN defined, a request SHALL be accepted only when the synchronized ball_det is 1; otherwise it is dropped. shoot_off is then also 1 in IDLE while ball_det is 0.
REQ-028 Without SHOOT_BALL_GATE_EN, ball_det and its synchronizer SHALL be ignored or removed, and requests gate on state only.

Structure
REQ-029 The shared package SHALL hold the state encoding (IDLE=2'd0, FIRE=2'd1, COOLDOWN=2'd2) and the default constants for PRESCALE, COOLDOWN_TICKS and MAX_WIDTH.
REQ-030 The prescaler SHALL be a sub-module, shoot_tick_gen, with ports clk, reset_n, clr and tick.

Verification (PRESCALE=4, COOLDOWN_TICKS=10, MAX_WIDTH=100)
REQ-031 Stimulus: kick_req with width 5 and chip_sel 0 in IDLE. Required: kick_out high for exactly 20 cycles, chip_out stays 0, shoot_off high for 20+40 cycles, then IDLE.
REQ-032 Stimulus: width 500 and chip_sel 1. Required: chip_out high for exactly 400 cycles (clamped to 100 ticks).
REQ-033 Stimulus: width 0, then a kick_req during FIRE, then a kick_req during COOLDOWN. Required: no pulse for the width-0 request, no pulse extension, and the later requests are dropped.
REQ-034 Stimulus: reset_n pulsed low 7 cycles into FIRE. Required: outputs go to 0 asynchronously; a new width-3 request afterwards gives a 12-cycle pulse.
REQ-035 With SHOOT_BALL_GATE_EN: ball_det=0 plus kick_req gives no pulse and shoot_off=1; after ball_det=1 is held 3 cycles, a request fires normally.

Source files
------------

// File: rtl/shoot_pulse_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// shoot_pulse_ctrl_pkg
// Shared definitions for the shooter pulse controller: FSM state encoding,
// default timing constants and the width clamp helper.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package shoot_pulse_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FIRE     = 2'd1,
    ST_COOLDOWN = 2'd2
  } shoot_state_e;

  localparam int unsigned DEF_PRESCALE       = 50;
  localparam int unsigned DEF_COOLDOWN_TICKS = 20000;
  localparam int unsigned DEF_MAX_WIDTH      = 8000;

  // One down-counter serves both the pulse width and the lockout, so it is
  // sized for the larger of the two (cooldown up to 2^20-1 ticks).
  localparam int unsigned CNT_W = 20;

  function automatic logic [CNT_W-1:0] clamp_width(input logic [15:0]      width,
                                                   input logic [CNT_W-1:0] max_w);
    logic [CNT_W-1:0] w_ext;
    w_ext = CNT_W'(width);
    return (w_ext > max_w) ? max_w : w_ext;
  endfunction

endpackage

// File: rtl/shoot_tick_gen.sv
// ---------------------------------------------------------------------------
// shoot_tick_gen
// Free-running prescaler: counts 0..PRESCALE-1 and flags a one-cycle tick on
// the terminal count. clr restarts the count so a new pulse gets a full first
// tick period.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   clr      in   synchronous restart of the count
//   tick     out  one-cycle timing tick
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module shoot_tick_gen
  import shoot_pulse_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] LP_TC = 16'(PRESCALE - 1);

  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == LP_TC)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // A clear on the terminal count must not also count as a tick.
  assign tick = (r_cnt == LP_TC) && !clr;

endmodule

// File: rtl/shoot_pulse_ctrl.sv
// ---------------------------------------------------------------------------
// shoot_pulse_ctrl
// Fires one solenoid pulse (flat kick or chip) per accepted request, timed in
// prescaler ticks, followed by a fixed lockout period.
//
// Optional build macro SHOOT_BALL_GATE_EN: requests are accepted only while
// the synchronized ball_det is high, and shoot_off also reports busy in IDLE
// while no ball is present.
//
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   kick_req    in   single-cycle shot request
//   kick_width  in   [15:0] pulse width in ticks (clamped to MAX_WIDTH)
//   chip_sel    in   1 = chip solenoid, 0 = flat kick solenoid
//   ball_det    in   asynchronous ball-present input
//   kick_out    out  flat solenoid drive (registered)
//   chip_out    out  chip solenoid drive (registered)
//   shoot_off   out  1 when a request cannot be accepted (registered)
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for a request, drives low
// FIRE     | selected drive high, counting width ticks down
// COOLDOWN | drives low, counting lockout ticks down, requests dropped
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module shoot_pulse_ctrl
  import shoot_pulse_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE       = DEF_PRESCALE,
  parameter int unsigned COOLDOWN_TICKS = DEF_COOLDOWN_TICKS,
  parameter int unsigned MAX_WIDTH      = DEF_MAX_WIDTH
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        kick_req,
  input  logic [15:0] kick_width,
  input  logic        chip_sel,
  input  logic        ball_det,
  output logic        kick_out,
  output logic        chip_out,
  output logic        shoot_off
);

  localparam logic [CNT_W-1:0] LP_COOL = CNT_W'(COOLDOWN_TICKS);
  localparam logic [CNT_W-1:0] LP_MAXW = CNT_W'(MAX_WIDTH);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

  shoot_state_e     r_state;
  shoot_state_e     w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_chip_sel;
  logic             w_chip_sel_nxt;
  logic             r_kick_out;
  logic             r_chip_out;
  logic             r_shoot_off;
  logic             w_kick_nxt;
  logic             w_chip_nxt;
  logic             w_shoot_off_nxt;
  logic             w_clr;
  logic             w_tick;
  logic             w_ball_ok;
  logic [CNT_W-1:0] w_width;

`ifdef SHOOT_BALL_GATE_EN
  logic r_ball_meta;
  logic r_ball_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ball_meta <= 1'b0;
      r_ball_sync <= 1'b0;
    end else begin
      r_ball_meta <= ball_det;
      r_ball_sync <= r_ball_meta;
    end
  end

  assign w_ball_ok = r_ball_sync;
`else
  // Ball sensor is not used in this build.
  logic w_unused_ball;
  assign w_unused_ball = ball_det;
  assign w_ball_ok     = 1'b1;
`endif

  shoot_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_clr),
    .tick    (w_tick)
  );

  assign w_width = clamp_width(kick_width, LP_MAXW);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_chip_sel  <= 1'b0;
      r_kick_out  <= 1'b0;
      r_chip_out  <= 1'b0;
      r_shoot_off <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_chip_sel  <= w_chip_sel_nxt;
      r_kick_out  <= w_kick_nxt;
      r_chip_out  <= w_chip_nxt;
      r_shoot_off <= w_shoot_off_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_chip_sel_nxt = r_chip_sel;
    w_clr          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (kick_req && (w_width != '0) && w_ball_ok) begin
          w_state_nxt    = ST_FIRE;
          w_cnt_nxt      = w_width;
          w_chip_sel_nxt = chip_sel;
          w_clr          = 1'b1;
        end
      end
      ST_FIRE: begin
        if (w_tick) begin
          if (r_cnt <= LP_ONE) begin
            w_state_nxt = ST_COOLDOWN;
            w_cnt_nxt   = LP_COOL;
          end else begin
            w_cnt_nxt = r_cnt - LP_ONE;
          end
        end
      end
      ST_COOLDOWN: begin
        if (w_tick) begin
          if (r_cnt <= LP_ONE) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - LP_ONE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // Outputs are decoded from the next state so the registered drives and
    // shoot_off change on the same edge as the state.
    w_kick_nxt      = (w_state_nxt == ST_FIRE) && !w_chip_sel_nxt;
    w_chip_nxt      = (w_state_nxt == ST_FIRE) &&  w_chip_sel_nxt;
    w_shoot_off_nxt = (w_state_nxt != ST_IDLE) || !w_ball_ok;
  end

  assign kick_out  = r_kick_out;
  assign chip_out  = r_chip_out;
  assign shoot_off = r_shoot_off;

endmodule

// File: tb/tb_shoot_pulse_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shoot_pulse_ctrl
// Scoreboard bench: the stimulus side decides from timing arithmetic whether a
// request is accepted and queues the expected pulse; a monitor measures each
// observed pulse and compares it against the queue head.
// Build with SHOOT_BALL_GATE_EN defined to exercise the ball gate.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_shoot_pulse_ctrl;

  localparam int PRE  = 4;
  localparam int COOL = 10;
  localparam int MAXW = 100;

  typedef struct {
    bit chip;
    int drv;
    int off;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        kick_req = 1'b0;
  logic [15:0] kick_width = '0;
  logic        chip_sel = 1'b0;
  logic        ball_det = 1'b1;
  logic        kick_out;
  logic        chip_out;
  logic        shoot_off;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edge_cnt = 0;
  int   next_ok = 0;
  bit   model_ball_ok = 1'b1;
  bit   ball_rand_en = 1'b0;

  int   m_phase = 0;
  bit   m_chip;
  int   m_drv, m_other, m_off;

  shoot_pulse_ctrl #(
    .PRESCALE       (PRE),
    .COOLDOWN_TICKS (COOL),
    .MAX_WIDTH      (MAXW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .kick_req   (kick_req),
    .kick_width (kick_width),
    .chip_sel   (chip_sel),
    .ball_det   (ball_det),
    .kick_out   (kick_out),
    .chip_out   (chip_out),
    .shoot_off  (shoot_off)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a request sampled at edge e is taken if the clamped width is
  // nonzero, the ball is present (gated builds) and the previous shot's
  // pulse plus lockout ((W+COOL)*PRE cycles) has fully elapsed.
  task automatic kick(input int w, input bit cs);
    int   e;
    int   wc;
    exp_t it;
    @(negedge clk);
    kick_req   = 1'b1;
    kick_width = 16'(w);
    chip_sel   = cs;
    e  = edge_cnt + 1;
    wc = (w > MAXW) ? MAXW : w;
    if (wc > 0 && model_ball_ok && e >= next_ok) begin
      it.chip = cs;
      it.drv  = wc * PRE;
      it.off  = (wc + COOL) * PRE;
      q.push_back(it);
      next_ok = e + (wc + COOL) * PRE + 1;
    end
    @(negedge clk);
    kick_req   = 1'b0;
    kick_width = 16'($urandom);
    chip_sel   = 1'($urandom);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      #2;
      if (q.size() == 0 && m_phase == 0) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: %0d expected pulses still pending, monitor phase %0d",
               q.size(), m_phase);
      q.delete();
      m_phase = 0;
    end
  endtask

  // Monitor: measures drive length, shoot_off length and any cycle where the
  // unselected drive is high, then compares against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        if (m_phase != 0 && q.size() > 0) void'(q.pop_front());
        m_phase = 0;
        continue;
      end
      if (m_phase == 0 && (kick_out || chip_out)) begin
        m_phase = 1;
        m_chip  = chip_out;
        m_drv   = 0;
        m_other = 0;
        m_off   = 0;
      end
      if (m_phase != 0) begin
        if (m_chip ? chip_out : kick_out) m_drv++;
        if (m_chip ? kick_out : chip_out) m_other++;
        if (shoot_off) begin
          m_off++;
        end else begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse: chip=%0d len=%0d, expected no pulse", m_chip, m_drv);
          end else begin
            e = q.pop_front();
            chk("chip_sel", int'(m_chip), int'(e.chip));
            chk("drive_len", m_drv, e.drv);
            chk("shoot_off_len", m_off, e.off);
            chk("other_drive", m_other, 0);
          end
          m_phase = 0;
        end
      end
    end
  end

  // Ball sensor noise must have no effect when the gate is not built in.
  always @(negedge clk) if (ball_rand_en) ball_det = 1'($urandom);

  initial begin
    int w;
    int sel;
`ifndef SHOOT_BALL_GATE_EN
    ball_rand_en = 1'b1;
`endif
    repeat (3) @(negedge clk);
    #2;
    chk("rst_kick_out", int'(kick_out), 0);
    chk("rst_chip_out", int'(chip_out), 0);
    chk("rst_shoot_off", int'(shoot_off), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_shoot_off", int'(shoot_off), 0);

    // flat kick, width 5
    kick(5, 1'b0);
    wait_idle();
    // clamped chip, width 500 -> 100 ticks
    kick(500, 1'b1);
    wait_idle();
    // zero width, then requests during FIRE and COOLDOWN
    kick(0, 1'b1);
    repeat (10) @(negedge clk);
    kick(10, 1'b0);
    repeat (5) @(negedge clk);
    kick(50, 1'b1);
    repeat (40) @(negedge clk);
    kick(7, 1'b1);
    wait_idle();

    // reset mid-pulse
    kick(20, 1'b0);
    repeat (6) @(negedge clk);
    #1;
    chk("pre_rst_kick_out", int'(kick_out), 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_kick_out", int'(kick_out), 0);
    chk("async_rst_chip_out", int'(chip_out), 0);
    chk("async_rst_shoot_off", int'(shoot_off), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    next_ok = 0;
    repeat (3) @(negedge clk);
    kick(3, 1'b1);
    wait_idle();

`ifdef SHOOT_BALL_GATE_EN
    ball_det = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    chk("gate_shoot_off", int'(shoot_off), 1);
    model_ball_ok = 1'b0;
    kick(5, 1'b0);
    repeat (40) @(negedge clk);
    wait_idle();
    ball_det = 1'b1;
    repeat (3) @(negedge clk);
    model_ball_ok = 1'b1;
    kick(5, 1'b0);
    wait_idle();
`endif

    // randomized requests; short gaps land many requests in FIRE/COOLDOWN
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 80)) @(negedge clk);
      sel = $urandom_range(0, 9);
      if (sel == 0)      w = 0;
      else if (sel == 1) w = 16'hFFFF;
      else if (sel == 2) w = $urandom_range(101, 600);
      else if (sel == 3) w = $urandom_range(99, 101);
      else               w = $urandom_range(1, 20);
      kick(w, 1'($urandom));
    end
    wait_idle();
    chk("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
